bod_sequencer: RTL and testbench

- Controller for the brownout-detection datapath: paces ADC conversions, gates the rate-calculator update strobe, and owns the system hold (reset-extend) output.
- Consumes the comparator flags bod_warn/bod_trip and the rate calculator's brownout flag; decides TRIP/RECOVER sequencing.
- Sits between the ADC interface, the rate calculator and the system reset generator.

---
 rtl/bod_pkg.sv | 14 +
 rtl/bod_sample_timer.sv | 77 +++++++
 rtl/bod_sequencer.sv | 148 ++++++++++++++
 tb/tb_bod_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bod_pkg.sv
// Shared definitions for the brownout-detection sequencer: state encoding
// and the default ADC sample width.
package bod_pkg;

    localparam int ADC_W_DEF = 20;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        WARN    = 2'd1,
        TRIP    = 2'd2,
        RECOVER = 2'd3
    } bod_state_e;

endpackage

// File: rtl/bod_sample_timer.sv
// Conversion pacing for the brownout sequencer: period down-counter,
// outstanding-conversion (busy) tracking and conversion timeout.
module bod_sample_timer #(
    parameter int SLOW_DIV = 1000,
    parameter int FAST_DIV = 50,
    parameter int TIMEOUT  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic adc_valid_i,
    input  logic reload_i,      // state change: restart period for the new state
    input  logic fast_i,        // new/current state uses the fast period
    output logic sample_req_o,
    output logic adc_timeout_o,
    output logic accept_o,      // adc_valid arrived while a conversion is outstanding
    output logic timeout_o      // conversion expires on this edge
);

    localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int TW     = $clog2(MAXDIV + 1);
    localparam int OW     = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d, period;
    logic [OW-1:0] age_q, age_d;
    logic          busy_q, busy_d;
    logic          req_ev;
    logic          req_q, tmo_q;

    // Request, accept and timeout events plus next-state of the counters
    always_comb begin
        period    = fast_i ? TW'(FAST_DIV - 1) : TW'(SLOW_DIV - 1);
        req_ev    = !busy_q && (timer_q == '0);
        accept_o  = busy_q && adc_valid_i;
        timeout_o = busy_q && !adc_valid_i && (age_q == OW'(TIMEOUT - 1));

        // The period keeps running during a conversion; it parks at zero
        // until the conversion finishes so the next request waits for it.
        timer_d = timer_q;
        if (req_ev || reload_i)
            timer_d = period;
        else if (timer_q != '0)
            timer_d = timer_q - 1'b1;

        busy_d = busy_q;
        if (req_ev)
            busy_d = 1'b1;
        else if (accept_o || timeout_o)
            busy_d = 1'b0;

        age_d = age_q;
        if (req_ev)
            age_d = '0;
        else if (busy_q)
            age_d = age_q + 1'b1;
    end

    // Counter and pulse registers; reset abandons any outstanding conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            age_q   <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            age_q   <= age_d;
            busy_q  <= busy_d;
            req_q   <= req_ev;
            tmo_q   <= timeout_o;
        end
    end

    assign sample_req_o  = req_q;
    assign adc_timeout_o = tmo_q;

endmodule

// File: rtl/bod_sequencer.sv
// Brownout-detection sequencer: paces ADC conversions, strobes the rate
// calculator in WARN, and drives the system hold through TRIP/RECOVER.
// Optional: define BOD_EVENT_CNT_EN to add a saturating trip_count output.
module bod_sequencer
    import bod_pkg::*;
#(
    parameter int ADC_W           = ADC_W_DEF,
    parameter int SLOW_DIV        = 1000,
    parameter int FAST_DIV        = 50,
    parameter int TIMEOUT         = 64,
    parameter int RECOVER_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             bod_warn,
    input  logic             bod_trip,
    input  logic             rate_flag,
    input  logic [ADC_W-1:0] recover_level,
    output logic             sample_req,
    output logic [ADC_W-1:0] adc_q,
    output logic             rate_en,
    output logic             sys_hold,
    output logic             adc_timeout,
    output logic [1:0]       state
`ifdef BOD_EVENT_CNT_EN
    ,
    output logic [15:0]      trip_count
`endif
);

    localparam int CW = $clog2(RECOVER_SAMPLES + 1);

    bod_state_e       state_q, state_d;
    logic [CW-1:0]    good_q, good_d;
    logic [ADC_W-1:0] smp_q, smp_d;
    logic             rate_en_q, rate_en_d;
    logic             hold_q, hold_d;
    logic             accept, tmo_ev, sample_good, state_chg;

    assign sample_good = (adc_data >= recover_level);
    assign state_chg   = (state_d != state_q);

    bod_sample_timer #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .adc_valid_i   (adc_valid),
        .reload_i      (state_chg),
        .fast_i        (state_d != MONITOR),
        .sample_req_o  (sample_req),
        .adc_timeout_o (adc_timeout),
        .accept_o      (accept),
        .timeout_o     (tmo_ev)
    );

    // State register; power-up holds the system until the rail proves good
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RECOVER;
        else
            state_q <= state_d;
    end

    // Next-state: a hard trip overrides everything, then per-state rules
    always_comb begin
        state_d = state_q;
        if (bod_trip) begin
            state_d = TRIP;
        end else begin
            case (state_q)
                MONITOR: if (bod_warn) state_d = WARN;
                WARN: begin
                    // rate_flag is meaningful only right after the strobe
                    if (rate_en_q && rate_flag)
                        state_d = TRIP;
                    else if (!bod_warn)
                        state_d = MONITOR;
                end
                TRIP:    if (!bod_warn) state_d = RECOVER;
                RECOVER: begin
                    if (bod_warn)
                        state_d = TRIP;
                    else if (accept && sample_good &&
                             good_q >= CW'(RECOVER_SAMPLES - 1))
                        state_d = MONITOR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs and datapath next-state: sample capture, strobe, hold, good count
    always_comb begin
        smp_d     = accept ? adc_data : smp_q;
        rate_en_d = accept && (state_q == WARN);
        hold_d    = (state_q == TRIP) || (state_q == RECOVER);

        good_d = good_q;
        if (state_q != RECOVER || tmo_ev) begin
            good_d = '0;
        end else if (accept) begin
            if (!sample_good)
                good_d = '0;
            else if (good_q < CW'(RECOVER_SAMPLES))
                good_d = good_q + 1'b1;
        end
    end

    // Output registers; hold follows the state one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q     <= '0;
            rate_en_q <= 1'b0;
            hold_q    <= 1'b1;
            good_q    <= '0;
        end else begin
            smp_q     <= smp_d;
            rate_en_q <= rate_en_d;
            hold_q    <= hold_d;
            good_q    <= good_d;
        end
    end

    assign adc_q    = smp_q;
    assign rate_en  = rate_en_q;
    assign sys_hold = hold_q;
    assign state    = state_q;

`ifdef BOD_EVENT_CNT_EN
    logic [15:0] trip_cnt_q;

    // Count entries into TRIP, saturating
    always_ff @(posedge clk) begin
        if (rst)
            trip_cnt_q <= '0;
        else if (state_d == TRIP && state_q != TRIP && trip_cnt_q != 16'hFFFF)
            trip_cnt_q <= trip_cnt_q + 16'd1;
    end

    assign trip_count = trip_cnt_q;
`endif

endmodule

// File: tb/tb_bod_sequencer.sv
// Directed bench for bod_sequencer with a small ADC responder that answers
// each sample_req two cycles later.
module tb_bod_sequencer;

    localparam int ADC_W = 20;
    localparam logic [19:0] GOOD  = 20'h80000;
    localparam logic [19:0] BAD   = 20'h10000;
    localparam logic [19:0] LEVEL = 20'h40000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             adc_valid = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             bod_warn = 1'b0, bod_trip = 1'b0, rate_flag = 1'b0;
    logic [ADC_W-1:0] recover_level = LEVEL;
    logic             sample_req, rate_en, sys_hold, adc_timeout;
    logic [ADC_W-1:0] adc_q;
    logic [1:0]       state;
`ifdef BOD_EVENT_CNT_EN
    logic [15:0]      trip_count;
`endif

    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    bod_sequencer #(
        .ADC_W(ADC_W), .SLOW_DIV(10), .FAST_DIV(4), .TIMEOUT(6), .RECOVER_SAMPLES(3)
    ) dut (
        .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .bod_warn(bod_warn), .bod_trip(bod_trip), .rate_flag(rate_flag),
        .recover_level(recover_level), .sample_req(sample_req), .adc_q(adc_q),
        .rate_en(rate_en), .sys_hold(sys_hold), .adc_timeout(adc_timeout),
        .state(state)
`ifdef BOD_EVENT_CNT_EN
        , .trip_count(trip_count)
`endif
    );

    // ADC responder: valid two cycles after each request, data from fifo or GOOD
    logic             resp_en = 1'b1;
    logic [ADC_W-1:0] data_fifo[$];
    logic [ADC_W-1:0] stray_data = '0;
    int stray_cnt = 0, stray_seen = 0, pend = 0, n_valid = 0;

    initial forever begin
        @(posedge clk); #1;
        adc_valid = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (data_fifo.size() > 0) adc_data = data_fifo.pop_front();
                    else adc_data = GOOD;
                    adc_valid = 1'b1;
                    n_valid++;
                end
            end
            if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                adc_data   = stray_data;
                adc_valid  = 1'b1;
            end
            if (sample_req && resp_en) pend = 2;
        end
    end

    // Event monitor sampled after each edge
    int cyc = 0, n_req = 0, n_rate = 0, n_tmo = 0, last_req = 0, prev_req = 0, last_tmo = 0;

    initial forever begin
        @(posedge clk); #2;
        cyc++;
        if (sample_req) begin prev_req = last_req; last_req = cyc; n_req++; end
        if (rate_en) n_rate++;
        if (adc_timeout) begin n_tmo++; last_tmo = cyc; end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic wait_req(input int limit, output bit ok);
        int start;
        start = n_req;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (n_req != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_state0(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (state == 2'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL reset_state: got %0d want 3", state); end
        n_cmp++; if (sys_hold !== 1'b1) begin n_err++; $display("FAIL reset_hold: got %b want 1", sys_hold); end
        n_cmp++; if (sample_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", sample_req); end
        n_cmp++; if (rate_en !== 1'b0) begin n_err++; $display("FAIL reset_rate_en: got %b want 0", rate_en); end
        n_cmp++; if (adc_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", adc_timeout); end
        n_cmp++; if (adc_q !== 20'h0) begin n_err++; $display("FAIL reset_adc_q: got %h want 0", adc_q); end
        rst = 1'b0;
        tick();
        n_cmp++; if (sample_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", sample_req); end
    endtask

    task automatic test_powerup_release();
        int v0, hold_bad;
        bit ok;
        v0 = n_valid;
        hold_bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state == 2'd0) begin ok = 1'b1; break; end
            if (sys_hold !== 1'b1) hold_bad++;
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL pwr_release_seen: got %b want 1", ok); end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL pwr_hold_during_recover: got %0d drops want 0", hold_bad); end
        n_cmp++; if (n_valid - v0 !== 3) begin n_err++; $display("FAIL pwr_samples: got %0d want 3", n_valid - v0); end
        n_cmp++; if (sys_hold !== 1'b1) begin n_err++; $display("FAIL pwr_hold_lag: got %b want 1", sys_hold); end
        tick();
        n_cmp++; if (sys_hold !== 1'b0) begin n_err++; $display("FAIL pwr_hold_release: got %b want 0", sys_hold); end
        wait_req(30, ok);
        wait_req(30, ok);
        n_cmp++; if (ok !== 1'b1 || last_req - prev_req !== 10) begin
            n_err++; $display("FAIL monitor_spacing: got %0d want 10", last_req - prev_req); end
    endtask

    task automatic test_warn();
        int r0;
        bit ok;
        bod_warn = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL warn_enter: got %0d want 1", state); end
        wait_req(20, ok);
        r0 = n_rate;
        wait_req(20, ok);
        wait_req(20, ok);
        wait_req(20, ok);
        n_cmp++; if (ok !== 1'b1 || last_req - prev_req !== 4) begin
            n_err++; $display("FAIL warn_spacing: got %0d want 4", last_req - prev_req); end
        n_cmp++; if (n_rate - r0 !== 3) begin n_err++; $display("FAIL warn_rate_en_count: got %0d want 3", n_rate - r0); end
        n_cmp++; if (sys_hold !== 1'b0) begin n_err++; $display("FAIL warn_hold: got %b want 0", sys_hold); end
        bod_warn = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL warn_exit: got %0d want 0", state); end
    endtask

    task automatic test_rate_trip();
        bit ok;
        bod_warn  = 1'b1;
        rate_flag = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rt_warn: got %0d want 1", state); end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rate_en === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rt_rate_en_seen: got %b want 1", ok); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rt_hold_warn: got %0d want 1", state); end
        tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL rt_trip: got %0d want 2", state); end
        n_cmp++; if (sys_hold !== 1'b0) begin n_err++; $display("FAIL rt_hold_lag: got %b want 0", sys_hold); end
        tick();
        n_cmp++; if (sys_hold !== 1'b1) begin n_err++; $display("FAIL rt_hold: got %b want 1", sys_hold); end
        rate_flag = 1'b0;
        bod_warn  = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL rt_recover: got %0d want 3", state); end
        wait_state0(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rt_release: got state %0d want 0", state); end
    endtask

    task automatic test_recover_pattern();
        int v0, bad;
        bit ok;
        bod_trip = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL rp_trip_from_monitor: got %0d want 2", state); end
        wait_req(20, ok);
        data_fifo.push_back(GOOD); data_fifo.push_back(GOOD); data_fifo.push_back(BAD);
        data_fifo.push_back(GOOD); data_fifo.push_back(GOOD); data_fifo.push_back(GOOD);
        bod_trip = 1'b0;
        v0 = n_valid;
        tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL rp_recover: got %0d want 3", state); end
        bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (state == 2'd0) begin ok = 1'b1; break; end
            if (state !== 2'd3) bad++;
        end
        n_cmp++; if (ok !== 1'b1 || bad !== 0) begin n_err++; $display("FAIL rp_release: got ok=%b stray=%0d want 1/0", ok, bad); end
        n_cmp++; if (n_valid - v0 !== 6) begin n_err++; $display("FAIL rp_sample_count: got %0d want 6", n_valid - v0); end
        n_cmp++; if (adc_q !== GOOD) begin n_err++; $display("FAIL rp_adc_q: got %h want %h", adc_q, GOOD); end
    endtask

    task automatic test_timeout();
        int r, t0;
        bit ok;
        resp_en = 1'b0;
        wait_req(30, ok);
        r = last_req;
        t0 = n_tmo;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_tmo != t0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1 || last_tmo - r !== 6) begin
            n_err++; $display("FAIL tmo_delay: got %0d want 6", last_tmo - r); end
        tick();
        n_cmp++; if (adc_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_width: got %b want 0", adc_timeout); end
        wait_req(20, ok);
        n_cmp++; if (ok !== 1'b1 || last_req - r !== 10) begin
            n_err++; $display("FAIL tmo_next_req: got %0d want 10", last_req - r); end
        // let this one time out too, then poke a valid while idle
        t0 = n_tmo;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_tmo != t0) break;
        end
        stray_data = 20'h12345;
        stray_cnt++;
        repeat (3) tick();
        n_cmp++; if (adc_q !== GOOD) begin n_err++; $display("FAIL stray_valid: got %h want %h", adc_q, GOOD); end
        resp_en = 1'b1;
    endtask

    task automatic test_trip_coincident();
        int r0;
        bit ok;
        bod_warn = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL tc_warn: got %0d want 1", state); end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (adc_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL tc_valid_seen: got %b want 1", ok); end
        bod_trip = 1'b1;
        r0 = n_rate;
        tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL tc_trip: got %0d want 2", state); end
        n_cmp++; if (rate_en !== 1'b1) begin n_err++; $display("FAIL tc_rate_en: got %b want 1", rate_en); end
        bod_trip = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL tc_stay_trip: got %0d want 2", state); end
        n_cmp++; if (n_rate - r0 !== 1) begin n_err++; $display("FAIL tc_rate_once: got %0d want 1", n_rate - r0); end
        bod_warn = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL tc_recover: got %0d want 3", state); end
        wait_state0(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL tc_release: got state %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_powerup_release();
        test_warn();
        test_rate_trip();
        test_recover_pattern();
        test_timeout();
        test_trip_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
